// File: rtl/braille_pkg.sv
// braille_pkg: shared widths, FSM state type and frame packing for the braille pin driver.
// Revision 1.0
`default_nettype none

package braille_pkg;

  localparam int CELL_W    = 8;
  localparam int NUM_CELLS = 4;
  localparam int FRAME_W   = CELL_W * NUM_CELLS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LATCH  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // Cell 4 occupies the top byte so its dot8 is the first bit on the wire.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [CELL_W-1:0] c1,
    input logic [CELL_W-1:0] c2,
    input logic [CELL_W-1:0] c3,
    input logic [CELL_W-1:0] c4
  );
    return {c4, c3, c2, c1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/braille_ser_shifter.sv
// braille_ser_shifter: MSB-first bit engine producing ser_data/ser_clk with a start/done handshake.
// Revision 1.0
`default_nettype none

module braille_ser_shifter
  import braille_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [FRAME_W-1:0] word_i,
  output logic               ser_data_o,
  output logic               ser_clk_o,
  output logic               done_o
);

  localparam int          DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [4:0]  LAST_BIT = 5'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               active_q, active_d;
  logic               sclk_q, sclk_d;
  logic               phase_end;

  assign phase_end  = (div_q == DIV_LAST);
  assign ser_data_o = shreg_q[FRAME_W-1];
  assign ser_clk_o  = sclk_q;
  assign done_o     = active_q && sclk_q && phase_end && (bit_cnt_q == LAST_BIT);

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    active_d  = active_q;
    sclk_d    = sclk_q;
    if (start_i) begin
      shreg_d   = word_i;
      bit_cnt_d = '0;
      div_d     = '0;
      active_d  = 1'b1;
      sclk_d    = 1'b0;
    end else if (active_q) begin
      if (!phase_end) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          // Clearing the shift register leaves ser_data low once the frame is out.
          if (bit_cnt_q == LAST_BIT) begin
            active_d = 1'b0;
            shreg_d  = '0;
          end else begin
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      active_q  <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      active_q  <= active_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/braille_pin_driver.sv
// braille_pin_driver: change/refresh-triggered serial frame sender with latch and settle timing.
// BLANK_ON_UPDATE_EN adds a 32-zero blank pass before each data pass. Revision 1.0
`default_nettype none

module braille_pin_driver
  import braille_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CELL_W-1:0] reader1_out,
  input  logic [CELL_W-1:0] reader2_out,
  input  logic [CELL_W-1:0] reader3_out,
  input  logic [CELL_W-1:0] reader4_out,
  input  logic              refresh,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              ser_latch,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DIV_W-1:0] LAT_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
`ifdef BLANK_ON_UPDATE_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  state_t             state_q;
  logic [FRAME_W-1:0] shadow_q;
  logic               shadow_valid_q;
  logic               refresh_pending_q;
  logic               blank_q;
  logic               latch_q;
  logic               busy_q;
  logic               frame_done_q;
  logic [DIV_W-1:0]   lat_cnt_q;
  logic [SET_W-1:0]   set_cnt_q;

  logic [FRAME_W-1:0] word;
  logic [FRAME_W-1:0] shift_word;
  logic               trigger;
  logic               data_restart;
  logic               shift_start;
  logic               shift_done;

  assign word = pack_frame(reader1_out, reader2_out, reader3_out, reader4_out);

  assign trigger = (state_q == IDLE) &&
                   (!shadow_valid_q || (word != shadow_q) || refresh_pending_q || refresh);

  // After a blank pass the data pass is launched straight from the last settle cycle.
  assign data_restart = (state_q == SETTLE) && (set_cnt_q == '0) && blank_q;
  assign shift_start  = trigger || data_restart;
  assign shift_word   = trigger ? (BLANK_EN ? '0 : word) : shadow_q;

  braille_ser_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .start_i    (shift_start),
    .word_i     (shift_word),
    .ser_data_o (ser_data),
    .ser_clk_o  (ser_clk),
    .done_o     (shift_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= IDLE;
      shadow_q          <= '0;
      shadow_valid_q    <= 1'b0;
      refresh_pending_q <= 1'b0;
      blank_q           <= 1'b0;
      latch_q           <= 1'b0;
      busy_q            <= 1'b0;
      frame_done_q      <= 1'b0;
      lat_cnt_q         <= '0;
      set_cnt_q         <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (refresh && (state_q != IDLE)) begin
        refresh_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (trigger) begin
            shadow_q          <= word;
            shadow_valid_q    <= 1'b1;
            refresh_pending_q <= 1'b0;
            blank_q           <= BLANK_EN;
            busy_q            <= 1'b1;
            state_q           <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            latch_q   <= 1'b1;
            lat_cnt_q <= '0;
            state_q   <= LATCH;
          end
        end
        LATCH: begin
          if (lat_cnt_q == LAT_LAST) begin
            latch_q   <= 1'b0;
            set_cnt_q <= SET_LOAD;
            state_q   <= SETTLE;
            if ((SETTLE_CYCLES == 1) && !blank_q) begin
              frame_done_q <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (set_cnt_q == '0) begin
            if (blank_q) begin
              blank_q <= 1'b0;
              state_q <= SHIFT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            set_cnt_q <= set_cnt_q - 1'b1;
            // frame_done is registered, so it is raised one cycle ahead of the last settle cycle.
            if ((set_cnt_q == SET_W'(1)) && !blank_q) begin
              frame_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ser_latch  = latch_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_braille_pin_driver.sv
// tb_braille_pin_driver: directed and random stimulus against a timeline model of the pin driver.
// Revision 1.0
`default_nettype none

module tb_braille_pin_driver;

  localparam int C  = 2;
  localparam int S  = 8;
  localparam int W1 = 65 * C + S;
`ifdef BLANK_ON_UPDATE_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int WT = NPASS * W1;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] r1, r2, r3, r4;
  logic refresh;
  logic ser_data, ser_clk, ser_latch, busy, frame_done;

  always #5 clk = ~clk;

  braille_pin_driver #(
    .CLK_DIV       (C),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reader1_out (r1),
    .reader2_out (r2),
    .reader3_out (r3),
    .reader4_out (r4),
    .refresh     (refresh),
    .ser_data    (ser_data),
    .ser_clk     (ser_clk),
    .ser_latch   (ser_latch),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  int checks = 0;
  int failures = 0;

  // Model: mt is the cycle index inside the busy window, -1 when idle.
  int          mt = -1;
  logic [31:0] mframe = '0;
  logic [31:0] mshadow = '0;
  bit          mvalid = 1'b0;
  bit          mpend = 1'b0;
  logic [31:0] expq[$];

  logic [31:0] cap = '0;
  int          ncap = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_latch = 1'b0;

  logic [7:0] ca, cb, cc, cd;

  function automatic logic [4:0] exp_out(input int t, input logic [31:0] fr);
    logic [31:0] f;
    int tt, pass, bi;
    logic d, sc, la;
    if (t < 0) return 5'b0;
    tt   = t % W1;
    pass = t / W1;
    f    = (NPASS == 2 && pass == 0) ? 32'h0 : fr;
    d = 1'b0; sc = 1'b0; la = 1'b0;
    if (tt < 64 * C) begin
      bi = tt / (2 * C);
      d  = f[31 - bi];
      sc = (tt % (2 * C)) >= C;
    end else if (tt < 65 * C) begin
      la = 1'b1;
    end
    return {d, sc, la, 1'b1, (t == WT - 1)};
  endfunction

  task automatic cycle(input logic rn, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input logic rf);
    logic [4:0]  obs, ex;
    logic [31:0] w, want;
    @(negedge clk);
    obs = {ser_data, ser_clk, ser_latch, busy, frame_done};
    ex  = exp_out(mt, mframe);
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL outputs t=%0d got=%b want=%b (data,clk,latch,busy,done)", mt, obs, ex);
    end
    if (ser_clk && !prev_sclk) begin
      cap = {cap[30:0], ser_data};
      ncap++;
    end
    if (ser_latch && !prev_latch) begin
      checks++;
      assert (expq.size() > 0) else begin
        failures++;
        $error("FAIL latch_expected got=unexpected latch want=no latch");
      end
      if (expq.size() > 0) begin
        want = expq.pop_front();
        checks++;
        assert (ncap === 32 && cap === want) else begin
          failures++;
          $error("FAIL frame_bits got=%08h (%0d rises) want=%08h (32 rises)", cap, ncap, want);
        end
      end
      ncap = 0;
      cap  = '0;
    end
    prev_sclk  = ser_clk;
    prev_latch = ser_latch;

    reset = rn; r1 = a; r2 = b; r3 = c; r4 = d; refresh = rf;
    w = {d, c, b, a};
    if (!rn) begin
      mt = -1; mvalid = 1'b0; mpend = 1'b0; mshadow = '0;
      expq.delete();
      ncap = 0; cap = '0;
    end else if (mt < 0) begin
      if (!mvalid || w != mshadow || mpend || rf) begin
        mt = 0; mframe = w; mshadow = w; mvalid = 1'b1; mpend = 1'b0;
        if (NPASS == 2) expq.push_back(32'h0);
        expq.push_back(w);
      end
    end else begin
      if (rf) mpend = 1'b1;
      mt++;
      if (mt == WT) mt = -1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, ca, cb, cc, cd, 1'b0);
  endtask

  task automatic pulse_refresh();
    cycle(1'b1, ca, cb, cc, cd, 1'b1);
  endtask

  function automatic bit in_latch();
    return (mt >= 0) && ((mt % W1) >= 64 * C) && ((mt % W1) < 65 * C);
  endfunction

  initial begin
    logic rn, rf;
    reset = 1'b0; r1 = '0; r2 = '0; r3 = '0; r4 = '0; refresh = 1'b0;
    repeat (3) @(posedge clk);

    // Forced frame of zeros after reset, then quiet idle.
    ca = 8'h00; cb = 8'h00; cc = 8'h00; cd = 8'h00;
    run(WT + 60);

    // 0x80000001 on the wire.
    ca = 8'h01; cb = 8'h00; cc = 8'h00; cd = 8'h80;
    run(WT + 20);

    // Mid-shift change of cell 2.
    ca = 8'h11; cb = 8'h22; cc = 8'h33; cd = 8'h44;
    run(20);
    cb = 8'h3C;
    run(2 * WT + 20);

    // Refresh pulses while busy collapse into one extra frame.
    cd = 8'h55;
    run(10);
    pulse_refresh(); run(30);
    pulse_refresh(); run(30);
    pulse_refresh();
    run(2 * WT + 20);
    pulse_refresh();
    run(WT + 20);

    // Reset during LATCH.
    cc = 8'hA5;
    for (int i = 0; i < 3 * WT && !in_latch(); i++) cycle(1'b1, ca, cb, cc, cd, 1'b0);
    checks++;
    assert (in_latch()) else begin
      failures++;
      $error("FAIL latch_wait got=not in latch want=in latch");
    end
    cycle(1'b0, ca, cb, cc, cd, 1'b0);
    run(WT + 20);

    // Random inputs, refreshes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: ca = 8'($urandom);
          1: cb = 8'($urandom);
          2: cc = 8'($urandom);
          default: cd = 8'($urandom);
        endcase
      end
      rf = ($urandom_range(0, 119) == 0);
      rn = !($urandom_range(0, 1499) == 0);
      cycle(rn, ca, cb, cc, cd, rf);
    end

    run(2 * WT + 10);
    checks++;
    assert (expq.size() == 0 && mt < 0) else begin
      failures++;
      $error("FAIL drain got=%0d frames outstanding want=0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
